regfile_wb_ctrl: RTL and testbench
==================================

Name: regfile_wb_ctrl

Overview:
- Controller for the 32x32 register file (2 read ports, 1 write port): owns the file's single write port (`wr`/`wadd`/`datain`).
- Arbitrates writeback between two requesters, the ALU and the load unit, with a bounded-starvation fixed-priority scheme.
- Keeps a per-register busy scoreboard and produces the issue-stage `stall` for RAW/WAW hazards.
- Sits between execute/memory writeback and the register file; the decode/issue stage consumes `stall`.

Parameters:
- DATA_W, 32, writeback data width.
- ADDR_W, 5, register address width (2**ADDR_W registers tracked).
- MAX_WAIT, 4, consecutive cycles the ALU may be denied before it is force-granted (1..15).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- alu_valid  in  1  ALU writeback request.
- alu_addr  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- alu_ready  out  1  ALU request accepted this cycle.
- mem_valid  in  1  load writeback request.
- mem_addr  in  ADDR_W  load destination register.
- mem_data  in  DATA_W  load data.
- mem_ready  out  1  load request accepted this cycle.
- rf_wr  out  1  register-file write enable (drives `wr`).
- rf_wadd  out  ADDR_W  register-file write address (drives `wadd`).
- rf_datain  out  DATA_W  register-file write data (drives `datain`).
- issue_valid  in  1  issue stage presents an instruction.
- issue_has_rd  in  1  instruction writes a destination register.
- issue_rd  in  ADDR_W  destination register.
- issue_rs1  in  ADDR_W  source register 1.
- issue_rs2  in  ADDR_W  source register 2.
- stall  out  1  hold issue this cycle.
- wb_err  out  1  sticky: a write committed to a non-busy register.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - rf_wr=0, rf_wadd=0, rf_datain=0, wb_err=0.
  - busy[*]=0, starvation counter=0.
  - Any accepted but uncommitted write is dropped.
  - The register-file contents are not touched.
- Handshake:
  - Transfer occurs when valid&ready.
  - A requester holds valid/addr/data stable until accepted; valid must not drop before acceptance.
  - alu_ready and mem_ready are combinational from the valids and the counter; at most one is 1 per cycle.
- Arbitration:
  - Default priority is mem over alu.
  - wait_cnt increments (saturating at MAX_WAIT) each cycle alu_valid=1 and ALU is not granted; it clears when the ALU is granted or alu_valid=0.
  - When wait_cnt==MAX_WAIT and alu_valid=1, the ALU is granted even if mem_valid=1.
  - With a single requester, it is granted immediately.
- Write pipeline: the granted request is registered; rf_wr pulses 1 cycle for exactly one clock, the cycle after acceptance (latency 1), with rf_wadd/rf_datain from the winner. Throughput is 1 write/cycle.
- Scoreboard:
  - `issue_go = issue_valid & ~stall`.
  - On issue_go & issue_has_rd, busy[issue_rd] is set at the posedge.
  - busy[rf_wadd] is cleared at the same posedge on which rf_wr=1 writes the file.
  - Set and clear of the same address at the same edge: set wins.
  - All 32 addresses are tracked; register 0 is an ordinary register, not hardwired zero.
- stall (combinational):
  - `stall = issue_valid & (busy[rs1] | busy[rs2] | (issue_has_rd & busy[rd]))`.
  - A register whose write is in the rf_wr cycle is still busy, so the reader stalls one more cycle and then reads the updated file value. No bypass.
- wb_err: set at the posedge where rf_wr=1 and busy[rf_wadd]=0; it stays set until rst.
- Same-address requests from both units in one cycle cannot be legal (prevented by the WAW stall); they are still serialised per arbitration, and the second commit raises wb_err.

Decomposition:
- Shared package `rf_pkg`: DATA_W, ADDR_W, NUM_REGS, and the writeback request struct {valid, addr, data}.
- One sub-module, `rf_scoreboard` (busy vector, set/clear logic, stall compare). Arbiter and write register stay in the top.

Test Plan:
- rst, then alu_valid with addr=3, data=0xDEADBEEF → alu_ready=1 same cycle; next cycle rf_wr=1, rf_wadd=3, rf_datain=0xDEADBEEF; file reg 3 reads 0xDEADBEEF the cycle after.
- mem_valid and alu_valid held continuously, MAX_WAIT=4 → mem granted 4 cycles, ALU granted on the 5th, pattern repeats; never both ready.
- Issue with has_rd=1, rd=7 → busy[7]. A following issue with rs1=7 stalls until the cycle after the rf_wr pulse for addr 7, then stall=0.
- Issue with has_rd=1, rd=5 in the same cycle rf_wr commits addr 5 → busy[5] remains 1 (set wins).
- Write commit to addr 9 with busy[9]=0 → wb_err=1 next cycle and stays 1; rst clears it.
- rst asserted the cycle after acceptance → rf_wr=0 that cycle, all busy cleared, stall=0 for any issue.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared widths and types for the register-file writeback controller.
// Imported by the interface, the scoreboard and the top.
package rf_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;
  localparam int WAIT_W   = 4;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_MEM  = 2'd2
  } grant_e;

endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Bundles the writeback requesters, register-file write port and issue-stage
// hazard signals. The master side drives requests; the slave side is the controller.
interface regfile_wb_ctrl_if;
  import rf_pkg::*;

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;

  logic              rf_wr;
  logic [ADDR_W-1:0] rf_wadd;
  logic [DATA_W-1:0] rf_datain;

  logic              issue_valid;
  logic              issue_has_rd;
  logic [ADDR_W-1:0] issue_rd;
  logic [ADDR_W-1:0] issue_rs1;
  logic [ADDR_W-1:0] issue_rs2;
  logic              stall;
  logic              wb_err;

  modport master (
    output alu_valid, alu_addr, alu_data,
    input  alu_ready,
    output mem_valid, mem_addr, mem_data,
    input  mem_ready,
    input  rf_wr, rf_wadd, rf_datain,
    output issue_valid, issue_has_rd, issue_rd, issue_rs1, issue_rs2,
    input  stall, wb_err
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    output alu_ready,
    input  mem_valid, mem_addr, mem_data,
    output mem_ready,
    output rf_wr, rf_wadd, rf_datain,
    input  issue_valid, issue_has_rd, issue_rd, issue_rs1, issue_rs2,
    output stall, wb_err
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy tracking and RAW/WAW issue stall for the writeback controller.
// A register stays busy through its rf_wr cycle, so readers never need a bypass.
module rf_scoreboard
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic              issue_has_rd,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] issue_rs1,
  input  logic [ADDR_W-1:0] issue_rs2,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  output logic              stall,
  output logic              clr_busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                issue_go;

  // Clear is applied before set so a new claim on the committing register wins.
  always_comb begin
    stall    = issue_valid & (busy_q[issue_rs1] | busy_q[issue_rs2] |
                              (issue_has_rd & busy_q[issue_rd]));
    issue_go = issue_valid & ~stall;
    clr_busy = busy_q[clr_addr];
    busy_d   = busy_q;
    if (clr_en) begin
      busy_d[clr_addr] = 1'b0;
    end
    if (issue_go && issue_has_rd) begin
      busy_d[issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Owns the register file's single write port: arbitrates ALU and load writebacks
// with a bounded-starvation fixed priority and registers the winner for one cycle.
module regfile_wb_ctrl
  import rf_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input logic              clk,
  input logic              rst,
  regfile_wb_ctrl_if.slave bus
);

  localparam logic [WAIT_W-1:0] MaxWait = WAIT_W'(MAX_WAIT);

  grant_e            grant;
  logic              force_alu;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_d;
  wb_req_t           wb_q;
  wb_req_t           wb_d;
  logic              wb_err_q;
  logic              wb_err_d;
  logic              commit;
  logic              commit_busy;

  // Loads normally win; an ALU denied MAX_WAIT cycles in a row is forced through.
  always_comb begin
    force_alu = bus.alu_valid && (wait_cnt_q == MaxWait);
    grant     = GNT_NONE;
    if (bus.alu_valid && (force_alu || !bus.mem_valid)) begin
      grant = GNT_ALU;
    end else if (bus.mem_valid) begin
      grant = GNT_MEM;
    end
  end

  assign bus.alu_ready = (grant == GNT_ALU);
  assign bus.mem_ready = (grant == GNT_MEM);

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!bus.alu_valid || grant == GNT_ALU) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q < MaxWait) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end

    wb_d = '0;
    case (grant)
      GNT_ALU: wb_d = '{valid: 1'b1, addr: bus.alu_addr, data: bus.alu_data};
      GNT_MEM: wb_d = '{valid: 1'b1, addr: bus.mem_addr, data: bus.mem_data};
      default: wb_d = '0;
    endcase

    wb_err_d = wb_err_q | (commit & ~commit_busy);
  end

  // Gating with rst drops a write that was accepted just before reset.
  assign commit        = wb_q.valid & ~rst;
  assign bus.rf_wr     = commit;
  assign bus.rf_wadd   = wb_q.addr;
  assign bus.rf_datain = wb_q.data;
  assign bus.wb_err    = wb_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      wb_q       <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      wb_q       <= wb_d;
      wb_err_q   <= wb_err_d;
    end
  end

  rf_scoreboard u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (bus.issue_valid),
    .issue_has_rd (bus.issue_has_rd),
    .issue_rd     (bus.issue_rd),
    .issue_rs1    (bus.issue_rs1),
    .issue_rs2    (bus.issue_rs2),
    .clr_en       (commit),
    .clr_addr     (wb_q.addr),
    .stall        (bus.stall),
    .clr_busy     (commit_busy)
  );

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: a scoreboard queue holds expected writes,
// a small behavioural model tracks grants, busy bits and the error flag.
module tb_regfile_wb_ctrl;
  import rf_pkg::*;

  localparam int MAX_WAIT = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic clk;
  logic rst;
  regfile_wb_ctrl_if bus ();

  regfile_wb_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int                checks = 0;
  int                errors = 0;
  exp_t              exp_q[$];
  logic [NUM_REGS-1:0] m_busy = '0;
  int                m_wait = 0;
  logic              m_err = 1'b0;
  logic              last_ga = 1'b0;
  logic              last_gm = 1'b0;
  logic              obs_alu_ready = 1'b0;
  logic              obs_mem_ready = 1'b0;
  logic [DATA_W-1:0] tb_rf [NUM_REGS];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in register file written through the controller's write port.
  always @(posedge clk) begin
    if (bus.rf_wr) tb_rf[bus.rf_wadd] <= bus.rf_datain;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock: check outputs against the model, push new grants, advance the model.
  task automatic applyStimulus();
    exp_t              e;
    logic              commit;
    logic [ADDR_W-1:0] caddr;
    logic              m_force, m_ga, m_gm, m_stall;
    commit = 1'b0;
    caddr  = '0;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (!rst) begin
        checkOutput("rf_wr", bus.rf_wr, 1);
        checkOutput("rf_wadd", bus.rf_wadd, e.addr);
        checkOutput("rf_datain", bus.rf_datain, e.data);
        commit = 1'b1;
        caddr  = e.addr;
      end else begin
        checkOutput("rf_wr_in_rst", bus.rf_wr, 0);
      end
    end else begin
      checkOutput("rf_wr_idle", bus.rf_wr, 0);
    end
    m_force = bus.alu_valid && (m_wait == MAX_WAIT);
    m_ga    = bus.alu_valid && (m_force || !bus.mem_valid);
    m_gm    = bus.mem_valid && !m_ga;
    obs_alu_ready = bus.alu_ready;
    obs_mem_ready = bus.mem_ready;
    checkOutput("alu_ready", bus.alu_ready, m_ga);
    checkOutput("mem_ready", bus.mem_ready, m_gm);
    if (m_ga) begin
      e.addr = bus.alu_addr; e.data = bus.alu_data; exp_q.push_back(e);
    end else if (m_gm) begin
      e.addr = bus.mem_addr; e.data = bus.mem_data; exp_q.push_back(e);
    end
    m_stall = bus.issue_valid && (m_busy[bus.issue_rs1] || m_busy[bus.issue_rs2] ||
                                  (bus.issue_has_rd && m_busy[bus.issue_rd]));
    checkOutput("stall", bus.stall, m_stall);
    checkOutput("wb_err", bus.wb_err, m_err);
    @(posedge clk);
    if (rst) begin
      m_busy = '0;
      m_wait = 0;
      m_err  = 1'b0;
      exp_q.delete();
    end else begin
      if (commit) begin
        if (!m_busy[caddr]) m_err = 1'b1;
        m_busy[caddr] = 1'b0;
      end
      if (bus.issue_valid && !m_stall && bus.issue_has_rd) m_busy[bus.issue_rd] = 1'b1;
      if (!bus.alu_valid || m_ga) m_wait = 0;
      else if (m_wait < MAX_WAIT) m_wait++;
    end
    last_ga = m_ga;
    last_gm = m_gm;
    #2;
  endtask

  initial begin
    rst = 1'b1;
    bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_data = '0;
    bus.issue_valid = 1'b0; bus.issue_has_rd = 1'b0;
    bus.issue_rd = '0; bus.issue_rs1 = '0; bus.issue_rs2 = '0;
    @(posedge clk); #2;
    applyStimulus();
    rst = 1'b0;
    checkOutput("rst_rf_wr", bus.rf_wr, 0);
    checkOutput("rst_rf_wadd", bus.rf_wadd, 0);
    checkOutput("rst_rf_datain", bus.rf_datain, 0);
    checkOutput("rst_wb_err", bus.wb_err, 0);

    // Basic ALU writeback to register 3.
    bus.issue_valid = 1'b1; bus.issue_has_rd = 1'b1; bus.issue_rd = 5'd3;
    applyStimulus();
    bus.issue_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd3; bus.alu_data = 32'hDEADBEEF;
    #1 checkOutput("alu_ready_same_cycle", bus.alu_ready, 1);
    applyStimulus();
    bus.alu_valid = 1'b0;
    checkOutput("wr_pulse", bus.rf_wr, 1);
    checkOutput("wr_addr", bus.rf_wadd, 3);
    checkOutput("wr_data", bus.rf_datain, 32'hDEADBEEF);
    applyStimulus();
    checkOutput("wr_pulse_end", bus.rf_wr, 0);
    checkOutput("file_reg3", tb_rf[3], 32'hDEADBEEF);

    // RAW hazard on register 7.
    bus.issue_valid = 1'b1; bus.issue_has_rd = 1'b1; bus.issue_rd = 5'd7;
    applyStimulus();
    bus.issue_has_rd = 1'b0; bus.issue_rs1 = 5'd7; bus.issue_rs2 = 5'd0;
    #1 checkOutput("raw_stall", bus.stall, 1);
    applyStimulus();
    applyStimulus();
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd7; bus.alu_data = 32'h12345678;
    applyStimulus();
    bus.alu_valid = 1'b0;
    #1 checkOutput("raw_stall_during_wr", bus.stall, 1);
    applyStimulus();
    #1 checkOutput("raw_release", bus.stall, 0);
    applyStimulus();
    bus.issue_valid = 1'b0; bus.issue_rs1 = '0;

    // Commit to a non-busy register raises a sticky error.
    bus.mem_valid = 1'b1; bus.mem_addr = 5'd9; bus.mem_data = 32'h00009999;
    applyStimulus();
    bus.mem_valid = 1'b0;
    applyStimulus();
    checkOutput("wb_err_set", bus.wb_err, 1);
    applyStimulus();
    applyStimulus();
    checkOutput("wb_err_sticky", bus.wb_err, 1);
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    checkOutput("wb_err_cleared", bus.wb_err, 0);

    // Set and clear of register 5 on the same edge: set wins.
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd5; bus.alu_data = 32'h00005555;
    applyStimulus();
    bus.alu_valid = 1'b0;
    bus.issue_valid = 1'b1; bus.issue_has_rd = 1'b1; bus.issue_rd = 5'd5;
    #1 checkOutput("set_wins_issue", bus.stall, 0);
    applyStimulus();
    bus.issue_has_rd = 1'b0; bus.issue_rs1 = 5'd5;
    #1 checkOutput("set_wins_busy", bus.stall, 1);
    applyStimulus();
    bus.issue_valid = 1'b0; bus.issue_rs1 = '0;

    // Both requesters held: four load grants, then a forced ALU grant.
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd10; bus.alu_data = 32'hA0000000;
    bus.mem_valid = 1'b1; bus.mem_addr = 5'd11; bus.mem_data = 32'hB0000000;
    for (int k = 0; k < 10; k++) begin
      applyStimulus();
      checkOutput("arb_alu_pattern", obs_alu_ready, (k % 5 == 4));
      checkOutput("arb_mem_pattern", obs_mem_ready, (k % 5 != 4));
      checkOutput("arb_exclusive", obs_alu_ready & obs_mem_ready, 0);
      if (last_ga) bus.alu_data = bus.alu_data + 32'd1;
      if (last_gm) bus.mem_data = bus.mem_data + 32'd1;
    end
    bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
    applyStimulus();
    checkOutput("arb_drained", exp_q.size(), 0);

    // Reset the cycle after acceptance drops the write and clears busy.
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    bus.issue_valid = 1'b1; bus.issue_has_rd = 1'b1; bus.issue_rd = 5'd12;
    applyStimulus();
    bus.issue_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd12; bus.alu_data = 32'h0000CAFE;
    applyStimulus();
    bus.alu_valid = 1'b0;
    rst = 1'b1;
    #1 checkOutput("rst_drops_wr", bus.rf_wr, 0);
    applyStimulus();
    rst = 1'b0;
    bus.issue_valid = 1'b1; bus.issue_has_rd = 1'b1; bus.issue_rd = 5'd12;
    bus.issue_rs1 = 5'd12; bus.issue_rs2 = 5'd5;
    #1 checkOutput("rst_clears_busy", bus.stall, 0);
    applyStimulus();
    bus.issue_valid = 1'b0;
    applyStimulus();
    checkOutput("final_wb_err", bus.wb_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
